// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, Nk/Nr per mode, rcon constants,
// xtime and the key-expansion state enum.
package aes_pkg;

  localparam logic [1:0] KL_128  = 2'd0;
  localparam logic [1:0] KL_192  = 2'd1;
  localparam logic [1:0] KL_256  = 2'd2;
  localparam logic [1:0] KL_RSVD = 2'd3;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DRAIN
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four independent byte S-box lookups on a 32-bit word.
module aes_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Byte 0x00 lives in the top 8 bits, 0xff in the bottom 8 bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      logic [10:0] sel;
      assign sel = 11'd2047 - {din[8*gi +: 8], 3'b000};
      assign dout[8*gi +: 8] = SBOX[sel -: 8];
    end
  endgenerate

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit word per cycle, round keys out over valid/ready.
// AES_WIDE_KEY_EN enables AES-192/256; without it the block is AES-128 only.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
);

`ifdef AES_WIDE_KEY_EN
  localparam int WIN = 8;
`else
  localparam int WIN = 4;
`endif

  state_t       state_reg;
  logic         busy_reg, done_reg;
  logic [5:0]   i_reg;
  logic [2:0]   mod_reg;
  logic [7:0]   rcon_reg;
  logic [31:0]  win_reg [WIN];
  logic [31:0]  win_load [WIN];
  logic [31:0]  asm_reg [3];
  logic [1:0]   asm_cnt_reg;
  logic [127:0] rk_reg;
  logic         rk_valid_reg;
  logic [3:0]   rk_idx_reg, round_reg;

  logic [3:0]   nk, nr, nk_start;
  logic         legal, accept, xfer, stall, step, in_key, rot_case, sw_case;
  logic [31:0]  prev, oldest, sub_in, sub_out, t, w_new;

`ifdef AES_WIDE_KEY_EN
  logic [1:0] kl_reg;

  assign legal    = (key_len != KL_RSVD);
  assign nk_start = nk_of(key_len);
  assign nk       = nk_of(kl_reg);
  assign nr       = nr_of(kl_reg);
  assign oldest   = win_reg[3'(nk - 4'd1)];
  assign sw_case  = !in_key && (nk == NK_256) && (mod_reg == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      kl_reg <= KL_128;
    else if (accept) kl_reg <= key_len;
  end
`else
  logic unused_key_len;

  assign unused_key_len = ^key_len;
  assign legal    = 1'b1;
  assign nk_start = NK_128;
  assign nk       = NK_128;
  assign nr       = NR_128;
  assign oldest   = win_reg[3];
  assign sw_case  = 1'b0;
`endif

  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] j);
    logic [255:0] sh;
    sh = k << {j, 5'b00000};
    return sh[255:224];
  endfunction

  // Window is preloaded reversed so the oldest slot yields w0..w[Nk-1] as it rotates.
  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_load
      assign win_load[gi] = (4'(gi) < nk_start) ? key_word(key, 3'(nk_start - 4'(gi + 1))) : '0;
    end
  endgenerate

  assign accept   = (state_reg == ST_IDLE) && start && legal;
  assign xfer     = rk_valid_reg && rk_ready;
  assign stall    = (asm_cnt_reg == 2'd3) && rk_valid_reg && !rk_ready;
  assign step     = (state_reg == ST_GEN) && !stall;
  assign in_key   = (i_reg < {2'b00, nk});
  assign rot_case = !in_key && (mod_reg == 3'd0);
  assign prev     = win_reg[0];
  assign sub_in   = rot_case ? {prev[23:0], prev[31:24]} : prev;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    t = prev;
    if (rot_case)     t = sub_out ^ {rcon_reg, 24'h0};
    else if (sw_case) t = sub_out;
    w_new = in_key ? oldest : (oldest ^ t);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: if (accept) begin
          state_reg <= ST_GEN;
          busy_reg  <= 1'b1;
        end
        ST_GEN: if (step && (i_reg == {nr, 2'b11})) state_reg <= ST_DRAIN;
        ST_DRAIN: if (xfer) begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg        <= '0;
      mod_reg      <= '0;
      rcon_reg     <= RCON_INIT;
      asm_cnt_reg  <= '0;
      rk_reg       <= '0;
      rk_valid_reg <= 1'b0;
      rk_idx_reg   <= '0;
      round_reg    <= '0;
      for (int k = 0; k < WIN; k++) win_reg[k] <= '0;
      for (int k = 0; k < 3; k++)   asm_reg[k] <= '0;
    end else if (accept) begin
      i_reg       <= '0;
      mod_reg     <= '0;
      rcon_reg    <= RCON_INIT;
      asm_cnt_reg <= '0;
      round_reg   <= '0;
      for (int k = 0; k < WIN; k++) win_reg[k] <= win_load[k];
    end else begin
      if (step) begin
        i_reg       <= i_reg + 6'd1;
        mod_reg     <= (mod_reg == 3'(nk - 4'd1)) ? 3'd0 : mod_reg + 3'd1;
        asm_cnt_reg <= asm_cnt_reg + 2'd1;
        if (rot_case) rcon_reg <= xtime(rcon_reg);
        win_reg[0] <= w_new;
        for (int k = 1; k < WIN; k++) win_reg[k] <= win_reg[k-1];
        if (asm_cnt_reg != 2'd3) asm_reg[asm_cnt_reg] <= w_new;
      end
      // A completed round key may replace the output in the same cycle it transfers.
      if (step && (asm_cnt_reg == 2'd3)) begin
        rk_reg       <= {asm_reg[0], asm_reg[1], asm_reg[2], w_new};
        rk_valid_reg <= 1'b1;
        rk_idx_reg   <= round_reg;
        round_reg    <= round_reg + 4'd1;
      end else if (xfer) begin
        rk_valid_reg <= 1'b0;
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rk_valid = rk_valid_reg;
  assign rk       = rk_reg;
  assign rk_idx   = rk_idx_reg;

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES key-schedule engine that expands a 128-, 192- or 256-bit cipher key into the full set of 128-bit round keys. It generates one 32-bit schedule word per cycle and computes the round constant sequentially with xtime, so no lookup table is used. Round keys stream out over a valid/ready handshake to the round datapath or to a round-key store. It generalises the round-constant lookup into a complete, multi-mode, flow-controlled expansion block.

## Interface
- Parameters: none. Modes are selected at run time. Wide-key support is a compile option (see Configuration).
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — begin an expansion; sampled only while idle.
- `key_len` in 2 — 0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = reserved. Sampled with `start`.
- `key` in 256 — cipher key, MSB-aligned. w0 = key[255:224]. A 128-bit key occupies key[255:128]. Sampled with `start`.
- `busy` out 1 — high from the accepted `start` until `done`.
- `rk_valid` out 1 — `rk` holds a round key.
- `rk_ready` in 1 — consumer accepts `rk`; a transfer occurs when `rk_valid & rk_ready`.
- `rk` out 128 — round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- `rk_idx` out 4 — round number r of `rk`, from 0 to Nr.
- `done` out 1 — one-cycle pulse after the final round key transfers.

## Operation
- **States:**
  - IDLE → GEN on `start` with a legal `key_len`.
  - GEN → DRAIN when word index i reaches 4·(Nr+1).
  - DRAIN → IDLE when the final round key (r = Nr) transfers; `done` pulses on this transition.
- **Ignored starts:** `start` in GEN or DRAIN is ignored. `start` with `key_len`=3 is ignored: the block stays IDLE and `busy` stays 0.
- **Word generation:** one word w[i] per non-stalled GEN cycle, for i = 0 … 4·(Nr+1)−1.
  - For i < Nk, w[i] is the captured key word.
  - Otherwise let t = w[i−1]:
    - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}.
    - Else if Nk = 8 and i mod 8 = 4: t = SubWord(t).
    - Then w[i] = w[i−Nk] ^ t.
- **Key window:** an 8-word shift register holding the last Nk words; w[i−Nk] is read at window depth Nk.
- **rcon register:** reset and `start` both load 8'h01. After each use it updates to {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
- **Round-key assembly:** a 4-word assembly buffer. When it fills, it moves into the `rk` output register if that register is empty or transferring in the same cycle. Otherwise word generation stalls: i, the window and rcon all hold.
- **Output stability:** `rk` and `rk_idx` are stable while `rk_valid & !rk_ready`.
- **Reset mid-operation:** aborts the expansion. All state and outputs return to their reset values and rcon returns to 8'h01.

## Timing
- **Reset values:** `busy`=0, `rk_valid`=0, `rk`=0, `rk_idx`=0, `done`=0, state=IDLE.
- **Start and first key:** `start` is accepted at edge E0 and `busy` is 1 after E0. w0 is written at E1 through w3 at E4. `rk_valid` (r=0) is 1 after E4.
- **Throughput:** with `rk_ready` held at 1, one round key every 4 cycles with no stalls. Totals are 44/52/60 word cycles for modes 0/1/2.
- **End of run:** `done` is 1 for exactly the cycle after the final transfer edge, and `busy` falls on that same edge. A new `start` is accepted in that cycle.
- **Back-pressure:** any number of `rk_ready`=0 cycles only delays output and never corrupts the schedule.

## Configuration
- **`AES_WIDE_KEY_EN` defined:** all three key lengths are supported, as above.
- **`AES_WIDE_KEY_EN` undefined:**
  - AES-128 only; `key_len` is ignored and treated as 0.
  - The window shrinks to 4 words; key[127:0] is unused.
  - The i mod 8 = 4 path is removed.

## Structure
- **Shared package `aes_pkg`:**
  - `key_len` encodings.
  - Nk/Nr constants per mode.
  - `RCON_INIT` = 8'h01 and `XTIME_POLY` = 8'h1b.
  - An xtime function.
  - A state enum.
- **Sub-module `aes_subword`:** combinational 32-bit SubWord built from four byte S-boxes. It is reused later by the cipher datapath.

## Test plan
- **AES-128, FIPS-197 A.1:** key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, `done` 45 cycles after start.
- **AES-192, A.2:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → w6 = fe0c91f7, w51 = 01002202, `rk_idx` reaches 12.
- **AES-256, A.3:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → w8 = 9ba35411, w12 = a8b09c1a (i mod 8 = 4 path), w59 = 706c631e.
- **Back-pressure:** A.1 key with `rk_ready` toggled pseudo-randomly (30% low) → identical rk sequence, `rk` stable while stalled.
- **Illegal and overlapping starts:** `key_len`=3 start → `busy` stays 0. A second `start` mid-run → ignored, sequence unchanged.
- **Reset mid-run:** `rst_n` low during round 5 → all outputs 0. A restart with the A.1 key reproduces rk1 exactly, proving rcon was reinitialised.
